// File: rtl/if_stage.sv
// Instruction fetch stage: PC, imem address, IF/ID register, redirect/stall/halt handling.
// Optional exception redirect and EPC register enabled by defining IFSTAGE_EXC_EN.
module if_stage #(
    parameter logic [15:0] RESET_PC   = 16'h0000,
    parameter logic [15:0] EXC_VECTOR = 16'h0010,
    parameter logic [15:0] NOP_INST   = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic [15:0] imem_addr,
    input  logic [15:0] imem_data,
    input  logic        wr_pc,
    input  logic        ifid_write,
    input  logic        br_taken,
    input  logic [15:0] br_target,
    input  logic        halt,
    input  logic        exc,
    input  logic [15:0] exc_pc,
    output logic [15:0] ifid_inst,
    output logic [15:0] ifid_pc_next,
    output logic        ifid_valid,
    output logic        halted,
    output logic [15:0] epc
);

    localparam int unsigned W = 16;

    typedef enum logic {RUN, HALT} state_t;

    state_t         state, state_d;
    logic [W-1:0]   pc, pc_d, pc_plus2;
    logic [W-1:0]   inst_d, pcn_d;
    logic           valid_d;

    assign pc_plus2  = pc + W'(2);
    assign imem_addr = pc;
    assign halted    = (state == HALT);

`ifdef IFSTAGE_EXC_EN
    logic [W-1:0] epc_q, epc_d;
    assign epc = epc_q;
`else
    logic unused_exc;
    assign unused_exc = ^{exc, exc_pc, EXC_VECTOR};
    assign epc = '0;
`endif

    // Next-state: exception > halt > taken branch > independent PC / IF/ID stalls > fetch
    always_comb begin
        state_d = state;
        pc_d    = pc;
        inst_d  = ifid_inst;
        pcn_d   = ifid_pc_next;
        valid_d = ifid_valid;
`ifdef IFSTAGE_EXC_EN
        epc_d   = epc_q;
`endif
        if (state == RUN) begin
`ifdef IFSTAGE_EXC_EN
            if (exc) begin
                pc_d    = EXC_VECTOR;
                epc_d   = exc_pc;
                inst_d  = NOP_INST;
                pcn_d   = '0;
                valid_d = 1'b0;
            end else
`endif
            if (halt) begin
                state_d = HALT;
                inst_d  = NOP_INST;
                pcn_d   = '0;
                valid_d = 1'b0;
            end else if (br_taken && wr_pc) begin
                pc_d    = br_target;
                inst_d  = NOP_INST;
                pcn_d   = '0;
                valid_d = 1'b0;
            end else begin
                if (wr_pc) begin
                    pc_d = pc_plus2;
                end
                if (ifid_write) begin
                    inst_d  = imem_data;
                    pcn_d   = pc_plus2;
                    valid_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= RUN;
            pc           <= RESET_PC;
            ifid_inst    <= NOP_INST;
            ifid_pc_next <= '0;
            ifid_valid   <= 1'b0;
        end else begin
            state        <= state_d;
            pc           <= pc_d;
            ifid_inst    <= inst_d;
            ifid_pc_next <= pcn_d;
            ifid_valid   <= valid_d;
        end
    end

`ifdef IFSTAGE_EXC_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            epc_q <= '0;
        end else begin
            epc_q <= epc_d;
        end
    end
`endif

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage; expected outputs queued per driven cycle and checked after the edge.
module tb_if_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] imem_addr, imem_data;
    logic        wr_pc, ifid_write, br_taken, halt, exc;
    logic [15:0] br_target, exc_pc;
    logic [15:0] ifid_inst, ifid_pc_next, epc;
    logic        ifid_valid, halted;

    int ncmp = 0;
    int nerr = 0;

`ifdef IFSTAGE_EXC_EN
    localparam logic [15:0] REDIR = 16'h0010;
    localparam logic [15:0] EPC_X = 16'h0020;
`else
    localparam logic [15:0] REDIR = 16'h0060;
    localparam logic [15:0] EPC_X = 16'h0000;
`endif

    typedef struct {
        string       tag;
        logic [15:0] addr;
        logic        valid;
        logic [15:0] inst;
        logic [15:0] pcn;
        logic        chk_pcn;
        logic        halted;
        logic [15:0] epc;
    } exp_t;

    exp_t sb[$];

    function automatic logic [15:0] mem(input logic [15:0] a);
        return a ^ 16'hC35A;
    endfunction

    assign imem_data = mem(imem_addr);

    always #5 clk = ~clk;

    if_stage dut (
        .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_data(imem_data),
        .wr_pc(wr_pc), .ifid_write(ifid_write), .br_taken(br_taken), .br_target(br_target),
        .halt(halt), .exc(exc), .exc_pc(exc_pc), .ifid_inst(ifid_inst),
        .ifid_pc_next(ifid_pc_next), .ifid_valid(ifid_valid), .halted(halted), .epc(epc)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input exp_t e);
        chk({e.tag, ".addr"},   imem_addr, e.addr);
        chk({e.tag, ".valid"},  16'(ifid_valid), 16'(e.valid));
        chk({e.tag, ".inst"},   ifid_inst, e.inst);
        if (e.chk_pcn) chk({e.tag, ".pcn"}, ifid_pc_next, e.pcn);
        chk({e.tag, ".halted"}, 16'(halted), 16'(e.halted));
        chk({e.tag, ".epc"},    epc, e.epc);
    endtask

    // Drive one cycle of inputs, queue the expected post-edge state, then pop and compare.
    task automatic cyc(input string tag, input logic w, input logic iw, input logic br,
                       input logic [15:0] tgt, input logic h, input logic ex, input logic [15:0] xpc,
                       input logic [15:0] e_addr, input logic e_valid, input logic [15:0] e_inst,
                       input logic [15:0] e_pcn, input logic e_chk, input logic e_halt,
                       input logic [15:0] e_epc);
        exp_t e;
        wr_pc = w; ifid_write = iw; br_taken = br; br_target = tgt;
        halt = h; exc = ex; exc_pc = xpc;
        e = '{tag, e_addr, e_valid, e_inst, e_pcn, e_chk, e_halt, e_epc};
        sb.push_back(e);
        @(posedge clk);
        @(negedge clk);
        if (sb.size() == 0) begin
            ncmp++; nerr++;
            $error("FAIL %s scoreboard empty observed=0 expected=1", tag);
        end else begin
            check_outputs(sb.pop_front());
        end
    endtask

    initial begin
        rst = 1'b0;
        wr_pc = 1'b1; ifid_write = 1'b1; br_taken = 1'b0; br_target = '0;
        halt = 1'b0; exc = 1'b0; exc_pc = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_outputs('{"reset", 16'h0000, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0000});
        rst = 1'b1;

        // free-running fetch
        cyc("run1", 1,1,0,16'h0,0,0,16'h0, 16'h0002,1,mem(16'h0000),16'h0002,1,0,16'h0);
        cyc("run2", 1,1,0,16'h0,0,0,16'h0, 16'h0004,1,mem(16'h0002),16'h0004,1,0,16'h0);
        cyc("run3", 1,1,0,16'h0,0,0,16'h0, 16'h0006,1,mem(16'h0004),16'h0006,1,0,16'h0);
        cyc("run4", 1,1,0,16'h0,0,0,16'h0, 16'h0008,1,mem(16'h0006),16'h0008,1,0,16'h0);
        // stall both PC and IF/ID at PC=0008
        cyc("stall1", 0,0,0,16'h0,0,0,16'h0, 16'h0008,1,mem(16'h0006),16'h0008,1,0,16'h0);
        cyc("stall2", 0,0,0,16'h0,0,0,16'h0, 16'h0008,1,mem(16'h0006),16'h0008,1,0,16'h0);
        cyc("resume", 1,1,0,16'h0,0,0,16'h0, 16'h000A,1,mem(16'h0008),16'h000A,1,0,16'h0);
        cyc("run5", 1,1,0,16'h0,0,0,16'h0, 16'h000C,1,mem(16'h000A),16'h000C,1,0,16'h0);
        cyc("run6", 1,1,0,16'h0,0,0,16'h0, 16'h000E,1,mem(16'h000C),16'h000E,1,0,16'h0);
        cyc("run7", 1,1,0,16'h0,0,0,16'h0, 16'h0010,1,mem(16'h000E),16'h0010,1,0,16'h0);
        // taken branch at PC=0010
        cyc("br", 1,1,1,16'h0040,0,0,16'h0, 16'h0040,0,16'h0000,16'h0,0,0,16'h0);
        cyc("br_tgt", 1,1,0,16'h0,0,0,16'h0, 16'h0042,1,mem(16'h0040),16'h0042,1,0,16'h0);
        // branch while stalled is ignored
        cyc("br_stall", 0,0,1,16'h0080,0,0,16'h0, 16'h0042,1,mem(16'h0040),16'h0042,1,0,16'h0);
        cyc("run8", 1,1,0,16'h0,0,0,16'h0, 16'h0044,1,mem(16'h0042),16'h0044,1,0,16'h0);
        // exception racing a taken branch
        cyc("exc", 1,1,1,16'h0060,0,1,16'h0020, REDIR,0,16'h0000,16'h0,0,0,EPC_X);
        cyc("exc_h", 1,1,0,16'h0,0,0,16'h0, REDIR+16'h2,1,mem(REDIR),REDIR+16'h2,1,0,EPC_X);
        // PC wrap
        cyc("br_wrap", 1,1,1,16'hFFFE,0,0,16'h0, 16'hFFFE,0,16'h0000,16'h0,0,0,EPC_X);
        cyc("wrap", 1,1,0,16'h0,0,0,16'h0, 16'h0000,1,mem(16'hFFFE),16'h0000,1,0,EPC_X);
        cyc("run9", 1,1,0,16'h0,0,0,16'h0, 16'h0002,1,mem(16'h0000),16'h0002,1,0,EPC_X);
        // halt, then everything ignored
        cyc("halt", 1,1,0,16'h0,1,0,16'h0, 16'h0002,0,16'h0000,16'h0,0,1,EPC_X);
        cyc("h_exc", 1,1,1,16'h0040,0,1,16'h0030, 16'h0002,0,16'h0000,16'h0,0,1,EPC_X);
        cyc("h_run", 1,1,0,16'h0,0,0,16'h0, 16'h0002,0,16'h0000,16'h0,0,1,EPC_X);

        // asynchronous reset mid-HALT
        #2 rst = 1'b0;
        #1 check_outputs('{"arst", 16'h0000, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0000});
        @(negedge clk);
        rst = 1'b1;
        cyc("post_rst", 1,1,0,16'h0,0,0,16'h0, 16'h0002,1,mem(16'h0000),16'h0002,1,0,16'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule

// File: doc/if_stage.md
# if_stage

Instruction fetch stage of the 16-bit pipelined CPU. It owns the program counter, drives the instruction-memory read address, and registers the fetched word into the IF/ID pipeline register consumed by decode. Branch redirects, load-use stalls, halts and exception redirects from downstream units are applied here with fixed priority.

## Interface

Parameters:
- RESET_PC, 16'h0000, PC value loaded on reset
- EXC_VECTOR, 16'h0010, fetch address taken on exception
- NOP_INST, 16'h0000, word inserted into IF/ID on bubble/flush

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- imem_addr  out  16  instruction memory read address (combinational from PC)
- imem_data  in  16  instruction word, combinational read of imem_addr
- wr_pc  in  1  from hazard unit; 0 holds PC
- ifid_write  in  1  from hazard unit; 0 holds IF/ID register
- br_taken  in  1  branch resolved taken in ID
- br_target  in  16  branch target address
- halt  in  1  halt request from hazard unit
- exc  in  1  exception request (setExc path)
- exc_pc  in  16  address of the excepting instruction
- ifid_inst  out  16  registered instruction
- ifid_pc_next  out  16  registered PC+2 of that instruction
- ifid_valid  out  1  1 = ifid_inst is a real instruction
- halted  out  1  1 in HALT state
- epc  out  16  saved exception PC

## Operation

- States: RUN, HALT. Reset -> RUN.
- Reset values: PC=RESET_PC, ifid_inst=NOP_INST, ifid_pc_next=16'h0000, ifid_valid=0, halted=0, epc=16'h0000.
- imem_addr = PC at all times.
- Per-cycle priority in RUN (highest first):
  - exc=1: PC<=EXC_VECTOR, epc<=exc_pc, IF/ID<=bubble (NOP_INST, valid 0). Ignores wr_pc/ifid_write.
  - halt=1: state<=HALT, PC held, IF/ID<=bubble.
  - br_taken=1 and wr_pc=1: PC<=br_target, IF/ID<=bubble (squash the fetched word).
  - br_taken=1 and wr_pc=0: branch ignored (ID stalled, decision not final).
  - wr_pc=0: PC held. ifid_write=0: IF/ID held. Each is independent.
  - Otherwise: PC<=PC+2, ifid_inst<=imem_data, ifid_pc_next<=PC+2, ifid_valid<=1.
- HALT: PC and epc frozen, IF/ID held at bubble, halted=1; all inputs ignored, including exc. Leave only via rst.
- Arithmetic: PC+2 modulo 2^16; 16'hFFFE wraps to 16'h0000. br_target and EXC_VECTOR used unmodified (bit 0 not masked).

## Timing

- All state updates on rising clk; rst asserted forces reset values immediately, independent of clk.
- Fetch-to-IF/ID latency: 1 cycle.
- Taken branch penalty: 1 bubble; target word appears in IF/ID 2 cycles after the br_taken cycle.
- Exception: EXC_VECTOR on imem_addr the cycle after exc; first handler word valid in IF/ID one cycle later.
- halted rises the cycle after halt is sampled.
- rst asserted mid-stall, mid-branch or in HALT: full reset, no partial state retained.
- rst deassertion: first fetch at RESET_PC; ifid_valid first rises on the following edge.

## Configuration

- IFSTAGE_EXC_EN defined: exception redirect and epc register as above.
- Not defined: exc and exc_pc ignored, no epc flop, epc tied 16'h0000, EXC_VECTOR unused; priority reduces to halt > branch > stall > normal.

## Test plan

- Reset then 4 free-running cycles with imem returning addr-derived words -> imem_addr 0000,0002,0004,0006; ifid_valid 0,1,1,1; ifid_pc_next 0002,0004,0006.
- wr_pc=0, ifid_write=0 for 2 cycles at PC=0008 -> imem_addr stays 0008, IF/ID unchanged; resumes to 000A after release.
- br_taken=1, br_target=0040 at PC=0010 -> next imem_addr 0040, IF/ID bubble (valid 0) one cycle, then word from 0040 with ifid_pc_next 0042; repeat with wr_pc=0 -> branch ignored.
- exc=1, exc_pc=0020, simultaneous br_taken=1 -> PC 0010 (EXC_VECTOR), epc 0020, bubble; with macro undefined -> branch taken instead, epc 0000.
- PC forced to FFFE via branch, normal cycle -> imem_addr 0000, ifid_pc_next 0000.
- halt=1 -> halted=1 next cycle, PC frozen, subsequent exc/br_taken ignored; rst low mid-HALT -> PC=0000, halted=0 asynchronously.
